// File: rtl/elastic_stage_if.sv
// Handshake bundle for elastic_stage: upstream valid/ready/data,
// downstream valid/ready/data, and the occupancy status.
// The master modport is the side that feeds and drains the stage.
// The slave modport is the stage itself.
interface elastic_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/elastic_stage.sv
// elastic_stage: two-entry elastic pipeline stage with a registered
// in_ready, so there is no combinational path from out_ready to in_ready.
// out_data always comes from the main register.
// A skid register catches the second word when the stage fills.
// With ENABLE=0 the stage collapses to wires.
module elastic_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ENABLE = 1
) (
    input logic            clk,
    input logic            rst,
    elastic_stage_if.slave bus
);

    if (ENABLE != 0) begin : g_reg

        // Encoding equals the number of held words.
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            BUSY  = 2'd1,
            FULL  = 2'd2
        } state_t;

        state_t           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_ready_q;
        logic             in_xfer;
        logic             out_xfer;

        assign in_xfer  = bus.in_valid & in_ready_q;
        assign out_xfer = (state_q != EMPTY) & bus.out_ready;

        // State, data registers and in_ready.
        // in_ready is (next state != FULL) registered.
        // It is also held low during reset, so it first rises on the
        // edge after reset release, and nothing is accepted on that edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= EMPTY;
                main_q     <= '0;
                skid_q     <= '0;
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= (state_d != FULL);
            end
        end

        // Next-state and data-path selection from the two transfer strobes.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = bus.in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = bus.in_data;
                    end else if (in_xfer) begin
                        skid_d  = bus.in_data;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_valid plays no part.
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        assign bus.in_ready  = in_ready_q;
        assign bus.out_valid = (state_q != EMPTY);
        assign bus.out_data  = main_q;
        assign bus.occupancy = state_q;

    end else begin : g_pass

        // Pass-through: no storage at all.
        assign bus.out_valid = bus.in_valid;
        assign bus.in_ready  = bus.out_ready;
        assign bus.out_data  = bus.in_data;
        assign bus.occupancy = 2'd0;

    end

endmodule

// File: tb/tb_elastic_stage.sv
// Bench for elastic_stage: directed vector table, hand-written reset
// sequences, and randomized traffic checked against a bounded-queue model.
// The pass-through build is checked separately.
module tb_elastic_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    elastic_stage_if #(.WIDTH(32)) ifc ();
    elastic_stage_if #(.WIDTH(32)) ifp ();

    elastic_stage #(.WIDTH(32), .ENABLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    elastic_stage #(.WIDTH(32), .ENABLE(0)) dut_pt (
        .clk (clk),
        .rst (rst),
        .bus (ifp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a FIFO of capacity two.
    // in_ready is "not full" as seen after each edge, and is low out of reset.
    logic [31:0] m_q[$];
    bit          m_rdy;

    typedef struct {
        bit          iv;
        logic [31:0] id;
        bit          ordy;
        bit          e_rdy;
        bit          e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        bit          chk_d;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input bit iv,
        input logic [31:0] id,
        input bit ordy,
        input bit e_rdy,
        input bit e_ov,
        input logic [31:0] e_od,
        input logic [1:0] e_occ,
        input bit chk_d
    );
        vec_t v;
        v.iv    = iv;
        v.id    = id;
        v.ordy  = ordy;
        v.e_rdy = e_rdy;
        v.e_ov  = e_ov;
        v.e_od  = e_od;
        v.e_occ = e_occ;
        v.chk_d = chk_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_in_ready", 32'(ifc.in_ready), 32'(m_rdy));
        chk("model_out_valid", 32'(ifc.out_valid), 32'(m_q.size() != 0));
        chk("model_occupancy", 32'(ifc.occupancy), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("model_out_data", ifc.out_data, m_q[0]);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rdy = 1'b0;
    endtask

    // One clock edge.
    // The model applies the transfers that the current inputs imply.
    // Outputs are then compared 1 time unit after the edge.
    task automatic tick();
        bit          ix;
        bit          ox;
        logic [31:0] d;
        ix = ifc.in_valid && m_rdy;
        ox = (m_q.size() != 0) && ifc.out_ready;
        d  = ifc.in_data;
        @(posedge clk);
        #1;
        if (ox) void'(m_q.pop_front());
        if (ix) m_q.push_back(d);
        m_rdy = (m_q.size() < 2);
        check_model();
    endtask

    initial begin
        logic [31:0] r_d;
        bit          r_v;
        bit          r_r;

        ifp.in_valid  = 1'b0;
        ifp.in_data   = '0;
        ifp.out_ready = 1'b0;

        // Reset release with a word already offered.
        rst           = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 32'hA5;
        ifc.out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_occupancy", 32'(ifc.occupancy), 32'd0);
        #6;
        rst = 1'b0;
        #1;
        chk("rel_in_ready_pre_edge", 32'(ifc.in_ready), 32'd0);
        tick();
        chk("rel_edge1_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rel_edge1_out_valid", 32'(ifc.out_valid), 32'd0);
        tick();
        chk("rel_edge2_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("rel_edge2_out_data", ifc.out_data, 32'h000000A5);
        chk("rel_edge2_occupancy", 32'(ifc.occupancy), 32'd1);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        tick();

        // Directed table: streaming, back-pressure, then drain from full.
        for (int k = 1; k <= 8; k++) begin
            vt.push_back(mk(1'b1, 32'(k), 1'b1, 1'b1, 1'b1, 32'(k), 2'd1, 1'b1));
        end
        vt.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0));
        vt.push_back(mk(1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1, 1'b1));
        vt.push_back(mk(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b1));
        vt.push_back(mk(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b1));
        vt.push_back(mk(1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1));
        vt.push_back(mk(1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1, 1'b1));
        vt.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0));
        vt.push_back(mk(1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 32'h44, 2'd1, 1'b1));
        vt.push_back(mk(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b1));
        vt.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h55, 2'd1, 1'b1));
        vt.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0));

        for (int i = 0; i < vt.size(); i++) begin
            ifc.in_valid  = vt[i].iv;
            ifc.in_data   = vt[i].id;
            ifc.out_ready = vt[i].ordy;
            tick();
            chk("vec_in_ready", 32'(ifc.in_ready), 32'(vt[i].e_rdy));
            chk("vec_out_valid", 32'(ifc.out_valid), 32'(vt[i].e_ov));
            chk("vec_occupancy", 32'(ifc.occupancy), 32'(vt[i].e_occ));
            if (vt[i].chk_d) chk("vec_out_data", ifc.out_data, vt[i].e_od);
        end

        // Asynchronous reset while full: outputs clear before the next edge.
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 32'h66;
        tick();
        ifc.in_data   = 32'h77;
        tick();
        chk("full_occupancy", 32'(ifc.occupancy), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("arst_occupancy", 32'(ifc.occupancy), 32'd0);
        chk("arst_out_data", ifc.out_data, 32'd0);
        chk("arst_in_ready", 32'(ifc.in_ready), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_ghost", 32'(ifc.out_valid), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.in_data   = $urandom;
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Pass-through build: outputs follow inputs in the same cycle.
        for (int i = 0; i < 40; i++) begin
            r_v = 1'($urandom_range(0, 1));
            r_r = 1'($urandom_range(0, 1));
            r_d = $urandom;
            ifp.in_valid  = r_v;
            ifp.out_ready = r_r;
            ifp.in_data   = r_d;
            #1;
            chk("pt_out_valid", 32'(ifp.out_valid), 32'(r_v));
            chk("pt_in_ready", 32'(ifp.in_ready), 32'(r_r));
            chk("pt_out_data", ifp.out_data, r_d);
            chk("pt_occupancy", 32'(ifp.occupancy), 32'd0);
            #2;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
